// File: rtl/link_pkg.sv
// Shared types and helpers for the transmit link scheduler.
// State encoding, default frame width and width helper.
package link_pkg;

    localparam int FRAME_W_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RETRY,
        S_DONE,
        S_RELEASE
    } state_t;

    // Never returns less than 1 so degenerate counters keep a legal width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_link_scheduler_if.sv
// Requester / transceiver bundle of the link scheduler.
// master drives requests and receiver status, slave is the scheduler.
interface tx_link_scheduler_if
    import link_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = FRAME_W_DEF
);
    logic [N_REQ-1:0]         Req;
    logic [N_REQ*FRAME_W-1:0] ReqData;
    logic                     RxReady;
    logic                     RxValid;
    logic                     TxStart;
    logic [FRAME_W-1:0]       TxFrame;
    logic [N_REQ-1:0]         Ack;
    logic [N_REQ-1:0]         Err;
    logic                     Busy;
    logic [2:0]               Owner;

    modport master (
        output Req, ReqData, RxReady, RxValid,
        input  TxStart, TxFrame, Ack, Err, Busy, Owner
    );

    modport slave (
        input  Req, ReqData, RxReady, RxValid,
        output TxStart, TxFrame, Ack, Err, Busy, Owner
    );
endinterface

// File: rtl/tx_link_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after
// the pointer, wrapping, as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PW-1:0]    o_idx
);
    logic [PW:0] w_pos;
    logic        w_hit;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_hit   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_pos >= (PW+1)'(N_REQ)) w_pos = w_pos - (PW+1)'(N_REQ);
            if (!w_hit && i_req[w_pos[PW-1:0]]) begin
                w_hit                   = 1'b1;
                o_grant[w_pos[PW-1:0]]  = 1'b1;
                o_idx                   = w_pos[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/tx_link_scheduler.sv
// Shares one serial transmitter/receiver loop among N requesters,
// with round-robin grant, receiver timeout and bounded retransmission.
module tx_link_scheduler
    import link_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_W   = FRAME_W_DEF,
    parameter int TIMEOUT   = 2000000,
    parameter int MAX_RETRY = 3,
    parameter int TO_W      = 21
) (
    input  logic                 CLK,
    input  logic                 nRST,
    tx_link_scheduler_if.slave   bus
);
    localparam int PW = clog2(N_REQ);
    localparam int RW = clog2(MAX_RETRY + 1);

    state_t             r_state;
    logic [PW-1:0]      r_pick;
    logic [N_REQ-1:0]   r_pick_oh;
    logic [PW-1:0]      r_owner;
    logic [N_REQ-1:0]   r_owner_oh;
    logic [PW-1:0]      r_ptr;
    logic [RW-1:0]      r_retry;
    logic [TO_W-1:0]    r_to;
    logic               r_txstart;
    logic [FRAME_W-1:0] r_frame;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_err;
    logic               r_busy;

    logic [N_REQ-1:0]   w_grant;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [FRAME_W-1:0] w_frames [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign w_frames[g] = bus.ReqData[g*FRAME_W +: FRAME_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .i_req   (bus.Req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_ptr_nxt = r_owner + PW'(1);
        if (r_owner == PW'(N_REQ - 1)) w_ptr_nxt = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_pick     <= '0;
            r_pick_oh  <= '0;
            r_owner    <= '0;
            r_owner_oh <= '0;
            r_ptr      <= '0;
            r_retry    <= '0;
            r_to       <= '0;
            r_txstart  <= 1'b0;
            r_frame    <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_txstart <= 1'b0;
            r_ack     <= '0;
            r_err     <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (|bus.Req) begin
                        r_pick    <= w_idx;
                        r_pick_oh <= w_grant;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_frame    <= w_frames[r_pick];
                    r_owner    <= r_pick;
                    r_owner_oh <= r_pick_oh;
                    r_retry    <= '0;
                    r_txstart  <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_to    <= '0;
                    r_state <= S_WAIT;
                end
                // A receiver answer on the expiry cycle takes precedence.
                S_WAIT: begin
                    if (bus.RxReady) begin
                        r_state <= bus.RxValid ? S_DONE : S_RETRY;
                    end else if (r_to == TO_W'(TIMEOUT - 1)) begin
                        r_state <= S_RETRY;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_RETRY: begin
                    if (r_retry < RW'(MAX_RETRY)) begin
                        r_retry   <= r_retry + RW'(1);
                        r_txstart <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_err   <= r_owner_oh;
                        r_state <= S_RELEASE;
                    end
                end
                S_DONE: begin
                    r_ack   <= r_owner_oh;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_ptr   <= w_ptr_nxt;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.TxStart = r_txstart;
    assign bus.TxFrame = r_frame;
    assign bus.Ack     = r_ack;
    assign bus.Err     = r_err;
    assign bus.Busy    = r_busy;
    assign bus.Owner   = 3'(r_owner);
endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler with TIMEOUT=50, MAX_RETRY=2.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_tx_link_scheduler;

    logic CLK;
    logic nRST;

    tx_link_scheduler_if #(.N_REQ(4), .FRAME_W(10)) bus ();

    tx_link_scheduler #(
        .N_REQ     (4),
        .FRAME_W   (10),
        .TIMEOUT   (50),
        .MAX_RETRY (2),
        .TO_W      (6)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_bad;
    int n_start;
    int n_ack;
    int n_err;
    int cyc;
    logic [3:0] last_ack;
    logic [3:0] last_err;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (bus.TxStart) n_start++;
        if (|bus.Ack) begin
            n_ack++;
            last_ack = bus.Ack;
        end
        if (|bus.Err) begin
            n_err++;
            last_err = bus.Err;
        end
    endtask

    task automatic clr_counts();
        n_start  = 0;
        n_ack    = 0;
        n_err    = 0;
        last_ack = '0;
        last_err = '0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.TxStart) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if ((|bus.Ack) || (|bus.Err)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_rx(input logic valid);
        bus.RxReady = 1'b1;
        bus.RxValid = valid;
        tick();
        bus.RxReady = 1'b0;
        bus.RxValid = 1'b0;
    endtask

    task automatic apply_reset();
        bus.Req     = '0;
        bus.ReqData = '0;
        bus.RxReady = 1'b0;
        bus.RxValid = 1'b0;
        nRST        = 1'b0;
        repeat (3) tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.Req     = '0;
        bus.ReqData = '0;
        bus.RxReady = 1'b0;
        bus.RxValid = 1'b0;
        nRST        = 1'b0;
        tick();
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got %b want 0", bus.Busy);
        end
        n_cmp++;
        if (bus.TxStart !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_txstart got %b want 0", bus.TxStart);
        end
        n_cmp++;
        if (bus.TxFrame !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_txframe got %h want 000", bus.TxFrame);
        end
        n_cmp++;
        if (bus.Ack !== 4'b0000 || bus.Err !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ack_err got %b/%b want 0000/0000", bus.Ack, bus.Err);
        end
        n_cmp++;
        if (bus.Owner !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_owner got %0d want 0", bus.Owner);
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        clr_counts();
        bus.ReqData[9:0] = 10'h2A5;
        bus.Req          = 4'b0001;
        wait_start(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_start got none want TxStart");
        end
        n_cmp++;
        if (bus.TxFrame !== 10'h2A5) begin
            n_bad++;
            $display("FAIL single_frame got %h want 2a5", bus.TxFrame);
        end
        repeat (19) tick();
        pulse_rx(1'b1);
        wait_end(ok);
        n_cmp++;
        if (!ok || last_ack !== 4'b0001 || n_err != 0) begin
            n_bad++;
            $display("FAIL single_ack got %b err %0d want 0001 err 0", last_ack, n_err);
        end
        n_cmp++;
        if (bus.Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_busy_release got %b want 1", bus.Busy);
        end
        bus.Req = '0;
        tick();
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Ack !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_idle got busy %b ack %b want 0 0000", bus.Busy, bus.Ack);
        end
        n_cmp++;
        if (n_start != 1 || n_ack != 1) begin
            n_bad++;
            $display("FAIL single_counts got start %0d ack %0d want 1 1", n_start, n_ack);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [2:0] exp_own;
        logic [9:0] exp_frm;
        logic [3:0] exp_ack;
        apply_reset();
        clr_counts();
        bus.ReqData = {10'h103, 10'h102, 10'h101, 10'h100};
        bus.Req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_own = 3'(k % 4);
            exp_frm = 10'h100 + 10'(k % 4);
            exp_ack = 4'b0001 << (k % 4);
            wait_start(ok);
            n_cmp++;
            if (!ok || bus.Owner !== exp_own || bus.TxFrame !== exp_frm) begin
                n_bad++;
                $display("FAIL rr_grant%0d got owner %0d frame %h want %0d %h",
                         k, bus.Owner, bus.TxFrame, exp_own, exp_frm);
            end
            repeat (3) tick();
            pulse_rx(1'b1);
            wait_end(ok);
            n_cmp++;
            if (!ok || bus.Ack !== exp_ack) begin
                n_bad++;
                $display("FAIL rr_ack%0d got %b want %b", k, bus.Ack, exp_ack);
            end
        end
        bus.Req = '0;
        tick();
        n_cmp++;
        if (n_ack != 5 || n_start != 5) begin
            n_bad++;
            $display("FAIL rr_counts got ack %0d start %0d want 5 5", n_ack, n_start);
        end
    endtask

    task automatic test_retry_invalid();
        bit ok;
        clr_counts();
        bus.ReqData[29:20] = 10'h3C3;
        bus.Req            = 4'b0100;
        wait_start(ok);
        n_cmp++;
        if (!ok || bus.Owner !== 3'd2) begin
            n_bad++;
            $display("FAIL retry_owner got %0d want 2", bus.Owner);
        end
        bus.ReqData[29:20] = 10'h0FF;
        repeat (5) tick();
        pulse_rx(1'b0);
        wait_start(ok);
        n_cmp++;
        if (!ok || bus.TxFrame !== 10'h3C3) begin
            n_bad++;
            $display("FAIL retry_frame got %h want 3c3", bus.TxFrame);
        end
        repeat (5) tick();
        pulse_rx(1'b0);
        wait_start(ok);
        repeat (5) tick();
        pulse_rx(1'b1);
        wait_end(ok);
        n_cmp++;
        if (!ok || last_ack !== 4'b0100 || n_err != 0) begin
            n_bad++;
            $display("FAIL retry_ack got %b err %0d want 0100 err 0", last_ack, n_err);
        end
        n_cmp++;
        if (n_start != 3) begin
            n_bad++;
            $display("FAIL retry_starts got %0d want 3", n_start);
        end
        bus.Req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int t0;
        int t1;
        int t2;
        clr_counts();
        bus.Req = 4'b0010;
        wait_start(ok);
        t0 = cyc;
        wait_start(ok);
        t1 = cyc;
        wait_start(ok);
        t2 = cyc;
        n_cmp++;
        if ((t1 - t0) != 52 || (t2 - t1) != 52) begin
            n_bad++;
            $display("FAIL timeout_spacing got %0d/%0d want 52/52", t1 - t0, t2 - t1);
        end
        wait_end(ok);
        n_cmp++;
        if (!ok || bus.Err !== 4'b0010 || n_ack != 0) begin
            n_bad++;
            $display("FAIL timeout_err got %b ack %0d want 0010 ack 0", bus.Err, n_ack);
        end
        bus.Req = '0;
        repeat (3) tick();
        n_cmp++;
        if (n_start != 3 || n_err != 1) begin
            n_bad++;
            $display("FAIL timeout_counts got start %0d err %0d want 3 1", n_start, n_err);
        end
    endtask

    task automatic test_rx_idle();
        clr_counts();
        pulse_rx(1'b1);
        pulse_rx(1'b0);
        repeat (3) tick();
        n_cmp++;
        if (n_ack != 0 || n_err != 0 || n_start != 0 || bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_idle got ack %0d err %0d start %0d busy %b want 0 0 0 0",
                     n_ack, n_err, n_start, bus.Busy);
        end
    endtask

    task automatic test_rx_at_timeout();
        bit ok;
        clr_counts();
        bus.Req = 4'b0001;
        wait_start(ok);
        repeat (50) tick();
        pulse_rx(1'b1);
        wait_end(ok);
        n_cmp++;
        if (!ok || last_ack !== 4'b0001 || n_err != 0 || n_start != 1) begin
            n_bad++;
            $display("FAIL rx_vs_timeout got ack %b err %0d start %0d want 0001 0 1",
                     last_ack, n_err, n_start);
        end
        bus.Req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_counts();
        bus.ReqData[39:30] = 10'h155;
        bus.Req            = 4'b1000;
        wait_start(ok);
        n_cmp++;
        if (!ok || bus.Owner !== 3'd3) begin
            n_bad++;
            $display("FAIL midrst_owner got %0d want 3", bus.Owner);
        end
        repeat (5) tick();
        nRST = 1'b0;
        tick();
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.TxFrame !== 10'h000 || bus.Owner !== 3'd0 ||
            bus.TxStart !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs got busy %b frame %h owner %0d start %b want 0 000 0 0",
                     bus.Busy, bus.TxFrame, bus.Owner, bus.TxStart);
        end
        bus.Req = 4'b1001;
        nRST    = 1'b1;
        wait_start(ok);
        n_cmp++;
        if (!ok || bus.Owner !== 3'd0) begin
            n_bad++;
            $display("FAIL midrst_first_owner got %0d want 0", bus.Owner);
        end
        repeat (2) tick();
        pulse_rx(1'b1);
        wait_end(ok);
        n_cmp++;
        if (!ok || last_ack !== 4'b0001 || n_ack != 1 || n_err != 0) begin
            n_bad++;
            $display("FAIL midrst_ack got %b count %0d err %0d want 0001 1 0",
                     last_ack, n_ack, n_err);
        end
        bus.Req = '0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        clr_counts();
        test_reset();
        test_single();
        test_round_robin();
        test_retry_invalid();
        test_timeout();
        test_rx_idle();
        test_rx_at_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
